// File: rtl/gamma_pixel_sequencer.sv
// Shares one registered gamma LUT across R, G and B of each pixel and reassembles the corrected pixel.
// The optional raw pass-through path is enabled by defining GAMMA_PIXEL_BYPASS_EN.
module gamma_pixel_sequencer #(
   parameter int COLOR_RES   = 8,
   parameter int LUT_LATENCY = 1,
   parameter bit OUT_GRB     = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3*COLOR_RES-1:0] in_rgb,
`ifdef GAMMA_PIXEL_BYPASS_EN
   input  logic                   bypass,
`endif
   output logic [COLOR_RES-1:0]   lut_addr,
   input  logic [COLOR_RES-1:0]   lut_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [3*COLOR_RES-1:0] out_rgb,
   output logic                   busy
);
   localparam int W = COLOR_RES;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t                 state_reg, state_next;
   logic [1:0]             issue_cnt_reg, issue_cnt_next;
   logic [1:0]             cap_cnt_reg;
   logic [3*W-1:0]         pix_reg;
   logic [W-1:0]           lut_addr_reg, lut_addr_next;
   logic [LUT_LATENCY-1:0] pipe_reg;
   logic                   accept;
   logic                   take_bypass;
   logic                   cap_fire;
   logic [W-1:0]           chan_val [3];

   assign accept   = in_valid && (state_reg == IDLE);
   assign cap_fire = pipe_reg[LUT_LATENCY-1];

`ifdef GAMMA_PIXEL_BYPASS_EN
   assign take_bypass = accept && bypass;
`else
   assign take_bypass = 1'b0;
`endif

   always_comb begin
      state_next     = state_reg;
      issue_cnt_next = issue_cnt_reg;
      lut_addr_next  = lut_addr_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               issue_cnt_next = '0;
               if (take_bypass) begin
                  state_next = HOLD;
               end else begin
                  // R goes out on the accept edge so it is on the bus in the first ISSUE cycle
                  state_next    = ISSUE;
                  lut_addr_next = in_rgb[3*W-1 -: W];
               end
            end
         end
         ISSUE: begin
            case (issue_cnt_reg)
               2'd0:    lut_addr_next = pix_reg[2*W-1 -: W];
               2'd1:    lut_addr_next = pix_reg[W-1:0];
               default: lut_addr_next = lut_addr_reg;
            endcase
            if (issue_cnt_reg == 2'd2) begin
               state_next     = WAIT;
               issue_cnt_next = '0;
            end else begin
               issue_cnt_next = issue_cnt_reg + 2'd1;
            end
         end
         WAIT: begin
            if (cap_fire && (cap_cnt_reg == 2'd2)) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         issue_cnt_reg <= '0;
         lut_addr_reg  <= '0;
         pix_reg       <= '0;
         cap_cnt_reg   <= '0;
         pipe_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         issue_cnt_reg <= issue_cnt_next;
         lut_addr_reg  <= lut_addr_next;
         if (accept) begin
            pix_reg <= in_rgb;
         end
         // Issue marker delayed by the LUT latency marks the cycle each lookup result is valid
         pipe_reg[0] <= (state_reg == ISSUE);
         for (int i = 1; i < LUT_LATENCY; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
         end
         if (cap_fire) begin
            cap_cnt_reg <= (cap_cnt_reg == 2'd2) ? 2'd0 : cap_cnt_reg + 2'd1;
         end
      end
   end

   // Channel 0 = R, 1 = G, 2 = B
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : gen_chan
         logic [W-1:0] chan_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               chan_reg <= '0;
            end else if (take_bypass) begin
               chan_reg <= in_rgb[(3-gi)*W-1 -: W];
            end else if (cap_fire && (cap_cnt_reg == 2'(gi))) begin
               chan_reg <= lut_data;
            end
         end
         assign chan_val[gi] = chan_reg;
      end
   endgenerate

   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign out_valid = (state_reg == HOLD);
   assign lut_addr  = lut_addr_reg;
   assign out_rgb   = OUT_GRB ? {chan_val[1], chan_val[0], chan_val[2]}
                              : {chan_val[0], chan_val[1], chan_val[2]};
endmodule

// File: tb/tb_gamma_pixel_sequencer.sv
// Directed bench: three sequencers share stimulus, each with its own 255-addr LUT model.
// Covers {R,G,B} and {G,R,B} packing at latency 1, latency 3, backpressure, reset and bypass.
module tb_gamma_pixel_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [23:0] in_rgb;
   logic        out_ready;
`ifdef GAMMA_PIXEL_BYPASS_EN
   logic        bypass;
`endif

   logic        in_ready_a, in_ready_b, in_ready_c;
   logic [7:0]  lut_addr_a, lut_addr_b, lut_addr_c;
   logic [7:0]  lut_data_a, lut_data_b, lut_data_c;
   logic [7:0]  lut_c_d1, lut_c_d2;
   logic        out_valid_a, out_valid_b, out_valid_c;
   logic [23:0] out_rgb_a, out_rgb_b, out_rgb_c;
   logic        busy_a, busy_b, busy_c;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // LUT models: data = 255 - addr, registered for latency 1, two extra stages for latency 3
   always @(posedge clk) begin
      lut_data_a <= 8'hFF - lut_addr_a;
      lut_data_b <= 8'hFF - lut_addr_b;
      lut_c_d1   <= 8'hFF - lut_addr_c;
      lut_c_d2   <= lut_c_d1;
      lut_data_c <= lut_c_d2;
   end

   gamma_pixel_sequencer #(.COLOR_RES(8), .LUT_LATENCY(1), .OUT_GRB(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_rgb(in_rgb),
`ifdef GAMMA_PIXEL_BYPASS_EN
      .bypass(bypass),
`endif
      .lut_addr(lut_addr_a), .lut_data(lut_data_a), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_rgb(out_rgb_a), .busy(busy_a));

   gamma_pixel_sequencer #(.COLOR_RES(8), .LUT_LATENCY(1), .OUT_GRB(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_rgb(in_rgb),
`ifdef GAMMA_PIXEL_BYPASS_EN
      .bypass(bypass),
`endif
      .lut_addr(lut_addr_b), .lut_data(lut_data_b), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_rgb(out_rgb_b), .busy(busy_b));

   gamma_pixel_sequencer #(.COLOR_RES(8), .LUT_LATENCY(3), .OUT_GRB(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .in_rgb(in_rgb),
`ifdef GAMMA_PIXEL_BYPASS_EN
      .bypass(bypass),
`endif
      .lut_addr(lut_addr_c), .lut_data(lut_data_c), .out_valid(out_valid_c),
      .out_ready(out_ready), .out_rgb(out_rgb_c), .busy(busy_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_rgb    = 24'h0;
      out_ready = 1'b1;
`ifdef GAMMA_PIXEL_BYPASS_EN
      bypass    = 1'b0;
`endif
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready_a), 32'd1);
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_rgb", 32'(out_rgb_a), 32'h0);
      check("rst_lut_addr", 32'(lut_addr_a), 32'h0);
      check("rst_busy", 32'(busy_a), 32'd0);
      rst_n = 1'b1;
      tick();

      // Pixel 1: 0x1080F0 with out_ready high
      in_valid = 1'b1;
      in_rgb   = 24'h1080F0;
      tick();                                        // cycle 1
      in_valid = 1'b0;
      in_rgb   = 24'hAAAAAA;
      check("p1_addr_c1", 32'(lut_addr_a), 32'h10);
      check("p1_in_ready_c1", 32'(in_ready_a), 32'd0);
      check("p1_busy_c1", 32'(busy_a), 32'd1);
      tick();                                        // cycle 2
      check("p1_addr_c2", 32'(lut_addr_a), 32'h80);
      tick();                                        // cycle 3
      check("p1_addr_c3", 32'(lut_addr_a), 32'hF0);
      tick();                                        // cycle 4
      check("p1_valid_c4", 32'(out_valid_a), 32'd0);
      tick();                                        // cycle 5
      check("p1_valid_a_c5", 32'(out_valid_a), 32'd1);
      check("p1_rgb_a", 32'(out_rgb_a), 32'hEF7F0F);
      check("p1_valid_b_c5", 32'(out_valid_b), 32'd1);
      check("p1_rgb_b_grb", 32'(out_rgb_b), 32'h7FEF0F);
      check("p1_valid_c_c5", 32'(out_valid_c), 32'd0);
      $display("pixel in=1080f0 out_a=%h out_b=%h", out_rgb_a, out_rgb_b);
      tick();                                        // cycle 6
      check("p1_valid_a_c6", 32'(out_valid_a), 32'd0);
      check("p1_in_ready_a_c6", 32'(in_ready_a), 32'd1);
      check("p1_addr_hold", 32'(lut_addr_a), 32'hF0);
      check("p1_valid_c_c6", 32'(out_valid_c), 32'd0);
      tick();                                        // cycle 7
      check("p1_valid_c_c7", 32'(out_valid_c), 32'd1);
      check("p1_rgb_c", 32'(out_rgb_c), 32'hEF7F0F);
      $display("pixel in=1080f0 out_c=%h", out_rgb_c);
      tick();                                        // cycle 8
      check("p1_in_ready_c_c8", 32'(in_ready_c), 32'd1);

      // Pixel 2: 0x00FF01 with downstream backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_rgb    = 24'h00FF01;
      tick();                                        // cycle 1
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();            // cycle 5
      check("p2_valid_a", 32'(out_valid_a), 32'd1);
      check("p2_rgb_a", 32'(out_rgb_a), 32'hFF00FE);
      in_valid = 1'b1;
      in_rgb   = 24'h555555;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("p2_hold_rgb", 32'(out_rgb_a), 32'hFF00FE);
         check("p2_hold_in_ready", 32'(in_ready_a), 32'd0);
         check("p2_hold_valid", 32'(out_valid_a), 32'd1);
      end
      check("p2_valid_c", 32'(out_valid_c), 32'd1);
      check("p2_rgb_c", 32'(out_rgb_c), 32'hFF00FE);
      $display("pixel in=00ff01 out_a=%h out_c=%h", out_rgb_a, out_rgb_c);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("p2_release_valid", 32'(out_valid_a), 32'd0);
      check("p2_release_in_ready", 32'(in_ready_a), 32'd1);
      check("p2_release_in_ready_c", 32'(in_ready_c), 32'd1);
      tick();
      check("p2_no_accept", 32'(busy_a), 32'd0);

      // Reset during cycle 2 of a lookup
      in_valid = 1'b1;
      in_rgb   = 24'h1080F0;
      tick();                                        // cycle 1
      in_valid = 1'b0;
      tick();                                        // cycle 2
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid_a), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready_a), 32'd1);
      check("mid_rst_addr", 32'(lut_addr_a), 32'h0);
      check("mid_rst_busy_c", 32'(busy_c), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", 32'(out_valid_a), 32'd0);

      // Pixel 3: 0x010203 after reset
      in_valid = 1'b1;
      in_rgb   = 24'h010203;
      tick();                                        // cycle 1
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();            // cycle 5
      check("p3_valid_a", 32'(out_valid_a), 32'd1);
      check("p3_rgb_a", 32'(out_rgb_a), 32'hFEFDFC);
      check("p3_rgb_b_grb", 32'(out_rgb_b), 32'hFDFEFC);
      tick();
      tick();                                        // cycle 7
      check("p3_valid_c", 32'(out_valid_c), 32'd1);
      check("p3_rgb_c", 32'(out_rgb_c), 32'hFEFDFC);
      $display("pixel in=010203 out_a=%h out_c=%h", out_rgb_a, out_rgb_c);
      tick();
      tick();

`ifdef GAMMA_PIXEL_BYPASS_EN
      // Bypass: raw pixel straight to HOLD, LUT address untouched
      check("byp_pre_addr", 32'(lut_addr_a), 32'h03);
      bypass   = 1'b1;
      in_valid = 1'b1;
      in_rgb   = 24'h123456;
      tick();                                        // cycle 1
      in_valid = 1'b0;
      bypass   = 1'b0;
      check("byp_valid_a", 32'(out_valid_a), 32'd1);
      check("byp_rgb_a", 32'(out_rgb_a), 32'h123456);
      check("byp_rgb_b_grb", 32'(out_rgb_b), 32'h341256);
      check("byp_addr", 32'(lut_addr_a), 32'h03);
      $display("pixel bypass in=123456 out_a=%h out_b=%h", out_rgb_a, out_rgb_b);
      tick();
      check("byp_done", 32'(out_valid_a), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gamma_pixel_sequencer.md
Name: gamma_pixel_sequencer

Overview:
Time-multiplexes one shared gamma lookup table across the R, G and B channels of a pixel stream. Accepts one packed RGB pixel per valid/ready handshake and issues three pipelined lookups to the external registered LUT. It captures the corrected bytes and presents the reassembled pixel on a valid/ready output to the LED serializer. Sits between the frame-buffer reader and the LED driver, and owns the LUT address port exclusively.

Parameters:
COLOR_RES, 8, bits per colour channel; LUT address and data width.
LUT_LATENCY, 1, clock cycles from lut_addr presented to lut_data valid (range 1..4).
OUT_GRB, 1, output packing: 1 = {G,R,B} (WS2812 order), 0 = {R,G,B}.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input pixel valid.
in_ready  out  1  sequencer can accept a pixel.
in_rgb  in  3*COLOR_RES  input pixel, R in MSBs, then G, then B in LSBs.
lut_addr  out  COLOR_RES  address to shared gamma table.
lut_data  in  COLOR_RES  gamma table output, valid LUT_LATENCY cycles after its address.
out_valid  out  1  corrected pixel valid.
out_ready  in  1  downstream accepts pixel.
out_rgb  out  3*COLOR_RES  corrected pixel, packed per OUT_GRB.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_rgb=0, lut_addr=0, busy=0, all counters and capture registers 0. Reset mid-pixel discards the pixel; no partial output is ever emitted.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready (cycle 0), latch in_rgb and go to ISSUE. in_ready is 0 in every other state.
- ISSUE: lasts exactly 3 cycles. lut_addr = R in cycle 1, G in cycle 2, B in cycle 3 (registered outputs). 2-bit issue counter 0..2. When the count is 2, go to WAIT.
- Capture: the lookup issued in cycle k (k=1..3) is sampled from lut_data at the end of cycle k+LUT_LATENCY. A capture counter tracks channel index independently of the issue counter; captures overlap ISSUE when LUT_LATENCY<3.
- WAIT: remains until the B capture (end of cycle 3+LUT_LATENCY), then goes to HOLD.
- HOLD: out_valid=1 from cycle 4+LUT_LATENCY (cycle 5 at default). out_rgb is stable while out_valid=1 and out_ready=0. On out_ready=1, out_valid drops the next cycle and the FSM returns to IDLE.
- Throughput: at most one pixel per 5+LUT_LATENCY cycles. There is no overlap between pixels: a new pixel is never accepted while the previous one is unaccepted downstream.
- lut_addr holds its last issued value outside ISSUE.
- in_rgb changes while not in IDLE are ignored.
- Width rules: captured values are stored unmodified, with no arithmetic on data.
- Packing: OUT_GRB=1 gives out_rgb = {G,R,B}; OUT_GRB=0 gives {R,G,B}.

Optional Feature:
Macro GAMMA_PIXEL_BYPASS_EN.
- Defined: adds input port bypass (1 bit), sampled together with the input handshake. If it is 1 at acceptance, the FSM goes IDLE->HOLD directly. lut_addr is not driven to new values, out_rgb is the raw latched pixel (still repacked per OUT_GRB), and out_valid rises in cycle 1. If bypass is 0, behaviour is the normal path.
- Undefined: no bypass port; every pixel goes through the LUT path.

Test Plan:
- Bench LUT model lut_data = 255-addr, registered, LUT_LATENCY=1, OUT_GRB=0. Send in_rgb=0x10_80_F0 with out_ready=1 -> out_valid in cycle 5 after accept, out_rgb=0xEF_7F_0F. lut_addr sequence 0x10, 0x80, 0xF0 in cycles 1-3.
- Same pixel with OUT_GRB=1 -> out_rgb=0x7F_EF_0F.
- out_ready held 0 for 10 cycles after out_valid -> out_rgb stable, in_ready=0 throughout, a second in_valid is not accepted. Release out_ready -> in_ready=1 the next cycle.
- LUT_LATENCY=3, pixel 0x00_FF_01 -> out_valid in cycle 7, out_rgb=0xFF_00_FE.
- Assert rst_n=0 in cycle 2 of a lookup -> out_valid=0, in_ready=1, lut_addr=0 immediately. The next pixel 0x01_02_03 yields 0xFE_FD_FC with no corruption.
- GAMMA_PIXEL_BYPASS_EN defined, bypass=1, pixel 0x12_34_56 -> out_valid in cycle 1, out_rgb=0x12_34_56, lut_addr unchanged.
